// File: rtl/uart_codeword_tx.sv
// uart_codeword_tx: serializes a 32-bit codeword as four back-to-back 8N1 UART frames, MSB byte first.
module uart_codeword_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data_in,
  output logic        tx,
  output logic        ready,
  output logic        done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [1:0] byte_idx, byte_n;
  logic [31:0] sh, sh_n;
  logic [7:0] cur_byte;
  logic tx_n, done_n, bit_end;
  assign bit_end  = cnt == LAST;
  assign cur_byte = sh[31:24];
  assign ready    = state == IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      sh       <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      sh       <= sh_n;
      tx       <= tx_n;
      done     <= done_n;
    end
  end
  // tx_n is the line level for the next cycle, so every transition also sets the new bit.
  always_comb begin
    state_n = state;
    cnt_n   = bit_end ? '0 : cnt + 1'b1;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    sh_n    = sh;
    tx_n    = tx;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (start) begin
          sh_n    = data_in;
          byte_n  = '0;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: if (bit_end) begin
        state_n = DATA;
        bit_n   = '0;
        tx_n    = cur_byte[0];
      end
      DATA: if (bit_end) begin
        if (bit_idx == 3'd7) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          bit_n = bit_idx + 3'd1;
          tx_n  = cur_byte[bit_idx + 3'd1];
        end
      end
      default: if (bit_end) begin
        if (byte_idx == 2'd3) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          byte_n  = byte_idx + 2'd1;
          sh_n    = {sh[23:0], 8'h00};
          tx_n    = 1'b0;
          state_n = START;
        end
      end
    endcase
  end
endmodule

// File: tb/tb_uart_codeword_tx.sv
// tb_uart_codeword_tx: scoreboard bench; a bench-side UART receiver and done monitor check against queued expectations.
module tb_uart_codeword_tx;
  localparam int C = 4;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [31:0] data_in = '0;
  logic tx, ready, done;
  int checks = 0, errors = 0, cyc = 0, acc = 0;
  logic [7:0] exp_bytes[$];
  int exp_done[$];
  uart_codeword_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .tx(tx), .ready(ready), .done(done)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Rate-1/2 K=3 (7,5) convolutional encoder with two flush bits: 14 message bits -> 32 code bits.
  function automatic logic [31:0] conv_enc(input logic [13:0] m);
    logic [2:0] s = '0;
    logic [31:0] r = '0;
    for (int i = 0; i < 16; i++) begin
      s = {(i < 14) ? m[13-i] : 1'b0, s[2:1]};
      r = {r[29:0], ^s, s[2] ^ s[0]};
    end
    return r;
  endfunction
  // Receiver and done monitor: samples each bit mid-period, pops the scoreboard per byte and per done.
  initial begin
    bit rx_busy = 0;
    int rx_cnt = 0;
    logic [7:0] rx_sh = '0;
    forever begin
      @(negedge clk);
      if (rst) rx_busy = 0;
      else if (!rx_busy) begin
        if (tx === 1'b0) begin
          rx_busy = 1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt == C/2) chk("start_bit", {31'd0, tx}, 32'd0);
        else if (rx_cnt >= C + C/2 && rx_cnt <= 8*C + C/2 && rx_cnt % C == C/2) rx_sh = {tx, rx_sh[7:1]};
        else if (rx_cnt == 9*C + C/2) begin
          chk("stop_bit", {31'd0, tx}, 32'd1);
          if (exp_bytes.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %h expected none", rx_sh);
          end else chk("rx_byte", {24'd0, rx_sh}, {24'd0, exp_bytes.pop_front()});
          rx_busy = 0;
        end
      end
      if (done === 1'b1 && !rst) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
        end else begin
          chk("done_cycle", cyc, exp_done.pop_front());
          chk("done_tx", {31'd0, tx}, 32'd1);
          chk("done_ready", {31'd0, ready}, 32'd1);
        end
      end
    end
  end
  task automatic send(input logic [31:0] d, input bit hold);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("ready_timeout", {31'd0, ready}, 32'd1);
    data_in = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    exp_done.push_back(cyc + 40*C);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(d[31-8*i -: 8]);
    chk("ready_drop", {31'd0, ready}, 32'd0);
    chk("tx_on_accept", {31'd0, tx}, 32'd0);
    if (!hold) start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (exp_done.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("done_timeout", exp_done.size(), 32'd0);
    @(negedge clk);
    chk("idle_bytes_left", exp_bytes.size(), 32'd0);
  endtask
  initial begin
    int a1, bad;
    #2 rst = 1'b1;
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(32'hA5C3_0F81, 0);
    bad = 0;
    repeat (40*C) begin
      @(negedge clk);
      if (ready !== 1'b0) bad++;
    end
    chk("ready_low_busy", bad, 32'd0);
    wait_done();
    send(conv_enc(14'b11010011101001), 0);
    wait_done();
    send(32'hFFFF_0000, 0);
    while (cyc < acc + 50) @(negedge clk);
    data_in = 32'h1234_5678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    send(32'h0000_0001, 1);
    a1 = acc;
    send(32'h8000_0000, 0);
    chk("b2b_gap", acc - a1, 32'd161);
    wait_done();
    send(32'hA5C3_0F81, 0);
    while (cyc < acc + 70) @(negedge clk);
    #2 rst = 1'b1;
    exp_bytes.delete();
    exp_done.delete();
    #1;
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    send(32'h3C96_E1D2, 0);
    wait_done();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
